// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV32I-subset core with one shared ALU, one FSM
// and a single unified req/ready memory port that tolerates wait states.
// Optional feature macro: RISCV_PERF_CNT_EN builds the cycle/instret counters;
// without it both counter outputs are tied to zero.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              illegal_instr,
    output logic              mem_err,
    output logic [31:0]       pc,
    output logic [63:0]       cycle_count,
    output logic [63:0]       instret_count
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    localparam logic [31:0] WAIT_LAST = (WAIT_MAX > 0) ? 32'(WAIT_MAX - 1) : 32'd0;
    localparam logic [6:0]  OP_LW  = 7'b0000011;
    localparam logic [6:0]  OP_SW  = 7'b0100011;
    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_BR  = 7'b1100011;
    localparam logic [6:0]  OP_JAL = 7'b1101111;

    state_t      state, state_nx;
    logic [31:0] pc_q, oldpc;
    logic [31:0] ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];
    logic [31:0] wait_cnt;
    logic [31:0] alu_x, alu_y, alu_res;
    logic [2:0]  alu_f3;
    logic        alu_sub;
    logic        req_state, acc, timeout, illegal_c, r_ok, i_ok;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Shared ALU: add/sub, signed set-less-than, or, and (selected by funct3).
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub,
                                        input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        logic [31:0]        r;
        sx = x;
        sy = y;
        case (f3)
            3'b010:  r = {31'd0, sx < sy};
            3'b110:  r = x | y;
            3'b111:  r = x & y;
            default: r = sub ? x - y : x + y;
        endcase
        return r;
    endfunction

    assign alu_res = alu(alu_f3, alu_sub, alu_x, alu_y);

    // Memory port: request is dropped at once by reset and for the cycle after a timeout.
    assign req_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign mem_req   = req_state && reset_n && !mem_err;
    assign mem_we    = mem_req && (state == MEMWR);
    assign mem_addr  = (state == FETCH) ? {pc_q[ADDR_W-1:2], 2'b00}
                                        : {alu_out[ADDR_W-1:2], 2'b00};
    assign mem_wdata = b;
    assign acc       = mem_req && mem_ready;
    assign timeout   = (WAIT_MAX != 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LAST);
    assign pc        = (state == FETCH) ? pc_q : oldpc;

    // Legal funct3/funct7 combinations for R-type and I-type ALU ops.
    always_comb begin
        case (funct3)
            3'b000:                 r_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
            3'b010, 3'b110, 3'b111: r_ok = (funct7 == 7'h00);
            default:                r_ok = 1'b0;
        endcase
    end
    assign i_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);

    // Next-state logic and ALU operand steering.
    always_comb begin
        state_nx  = state;
        alu_x     = a;
        alu_y     = b;
        alu_f3    = 3'b000;
        alu_sub   = 1'b0;
        illegal_c = 1'b0;
        case (state)
            FETCH:  if (acc) state_nx = DECODE;
            DECODE: begin
                alu_x = oldpc;
                alu_y = imm_b;
                case (opcode)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECR;
                    OP_I:         state_nx = EXECI;
                    OP_JAL:       state_nx = JAL;
                    OP_BR: begin
                        if (funct3 == 3'b000) begin
                            state_nx = BEQ;
                        end else begin
                            illegal_c = 1'b1;
                            state_nx  = FETCH;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_nx  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_y    = (opcode == OP_SW) ? imm_s : imm_i;
                state_nx = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD:  if (acc) state_nx = MEMWB;
            MEMWB:  state_nx = FETCH;
            MEMWR:  if (acc) state_nx = FETCH;
            EXECR: begin
                alu_f3    = funct3;
                alu_sub   = funct7[5];
                illegal_c = !r_ok;
                state_nx  = r_ok ? ALUWB : FETCH;
            end
            EXECI: begin
                alu_y     = imm_i;
                alu_f3    = funct3;
                illegal_c = !i_ok;
                state_nx  = i_ok ? ALUWB : FETCH;
            end
            ALUWB:  state_nx = FETCH;
            BEQ:    state_nx = FETCH;
            JAL: begin
                alu_x    = oldpc;
                alu_y    = imm_j;
                state_nx = ALUWB;
            end
            default: state_nx = FETCH;
        endcase
        if (timeout) state_nx = FETCH;
    end

    // Control state: FSM, PC, stall counter and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            pc_q          <= RESET_PC;
            oldpc         <= RESET_PC;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            state         <= state_nx;
            illegal_instr <= illegal_c;
            mem_err       <= timeout;
            if (mem_req && !mem_ready && !timeout) wait_cnt <= wait_cnt + 32'd1;
            else                                   wait_cnt <= '0;
            if (state == FETCH && acc) begin
                oldpc <= pc_q;
                pc_q  <= pc_q + 32'd4;
            end else if (state == BEQ && a == b) begin
                pc_q  <= alu_out;
            end else if (state == JAL) begin
                pc_q  <= alu_res;
            end
        end
    end

    // Datapath registers: instruction, operands, ALU result and load data.
    always_ff @(posedge clk) begin
        case (state)
            FETCH:                if (acc) ir <= mem_rdata;
            DECODE: begin
                a       <= regs[rs1];
                b       <= regs[rs2];
                alu_out <= alu_res;
            end
            MEMADR, EXECR, EXECI: alu_out <= alu_res;
            MEMRD:                if (acc) mdr <= mem_rdata;
            JAL:                  alu_out <= pc_q;
            default: ;
        endcase
    end

    // Register file write-back; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rd != 5'd0) begin
            if (state == MEMWB)      regs[rd] <= mdr;
            else if (state == ALUWB) regs[rd] <= alu_out;
        end
    end

`ifdef RISCV_PERF_CNT_EN
    logic        retire;
    logic [63:0] cyc_q, ret_q;

    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWR) && acc);

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (retire) ret_q <= ret_q + 64'd1;
        end
    end

    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed testbench for riscv_multicycle with a wait-state memory model.
module tb_riscv_multicycle;

    localparam logic [6:0] OP_I  = 7'h13;
    localparam logic [6:0] OP_LW = 7'h03;
`ifdef RISCV_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        illegal_instr, mem_err;
    logic [31:0] pc;
    logic [63:0] cycle_count, instret_count;

    logic [31:0] mem [64];
    int          waits, wcnt, st_hold;
    bit          stuck;
    int          n_pass, n_total;
    logic [8:0]  ill_seq;

    riscv_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .WAIT_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .illegal_instr(illegal_instr), .mem_err(mem_err), .pc(pc),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 'waits' stall cycles per access, updated on the falling edge.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !stuck) begin
                if (wcnt < waits) begin
                    mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    mem_ready = 1'b1;
                    wcnt      = 0;
                    mem_rdata = mem[mem_addr[7:2]];
                    if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            if (mem_req && mem_we && mem_addr == 32'd8 && mem_wdata == 32'd12) st_hold++;
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        st_hold = 0;
    endtask

    task automatic start();
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b1;
        waits   = 0;
        stuck   = 1'b0;
        st_hold = 0;
        #1 reset_n = 1'b0;

        // ---- ALU program, zero-wait memory ----
        enter_reset();
        mem[0]  = enc_i(5, 0, 0, 1, OP_I);
        mem[1]  = enc_i(7, 0, 0, 2, OP_I);
        mem[2]  = enc_r(7'h00, 2, 1, 0, 3);
        mem[3]  = enc_i(-3, 0, 0, 11, OP_I);
        mem[4]  = enc_i(5, 0, 0, 12, OP_I);
        mem[5]  = enc_r(7'h20, 12, 11, 0, 13);
        mem[6]  = enc_r(7'h00, 12, 11, 2, 14);
        mem[7]  = enc_r(7'h00, 12, 11, 7, 15);
        mem[8]  = enc_r(7'h00, 12, 11, 6, 16);
        mem[9]  = enc_i(-1, 12, 2, 17, OP_I);
        mem[10] = enc_i(15, 11, 7, 18, OP_I);
        mem[11] = enc_i(32'h100, 12, 6, 19, OP_I);
        mem[12] = enc_r(7'h00, 11, 12, 2, 20);
        step(2);
        chk("rst_req", 64'(mem_req), 0);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_ill", 64'(illegal_instr), 0);
        chk("rst_err", 64'(mem_err), 0);
        chk("rst_pc", 64'(pc), 0);
        chk("rst_cyc", cycle_count, 0);
        chk("rst_ret", instret_count, 0);
        start();
        chk("fetch_req", 64'(mem_req), 1);
        step(11);
        chk("add_early", 64'(dut.regs[3]), 0);
        step(1);
        chk("add_x3", 64'(dut.regs[3]), 12);
        chk("add_x1", 64'(dut.regs[1]), 5);
        chk("add_x2", 64'(dut.regs[2]), 7);
        chk("pc_4th_fetch", 64'(pc), 12);
        chk("instret_3", instret_count, PERF ? 64'd3 : 64'd0);
        chk("cycles_12", cycle_count, PERF ? 64'd12 : 64'd0);
        step(40);
        chk("sub", 64'(dut.regs[13]), 64'hFFFF_FFF8);
        chk("slt_neg", 64'(dut.regs[14]), 1);
        chk("and", 64'(dut.regs[15]), 5);
        chk("or", 64'(dut.regs[16]), 64'hFFFF_FFFD);
        chk("slti_signed", 64'(dut.regs[17]), 0);
        chk("andi", 64'(dut.regs[18]), 13);
        chk("ori", 64'(dut.regs[19]), 64'h105);
        chk("slt_signed", 64'(dut.regs[20]), 0);
        chk("instret_13", instret_count, PERF ? 64'd13 : 64'd0);

        // ---- store/load with two wait states per access ----
        enter_reset();
        waits   = 2;
        mem[0]  = enc_i(12, 0, 0, 3, OP_I);
        mem[1]  = enc_j(32'h1C, 0);
        mem[8]  = enc_s(8, 3, 0);
        mem[9]  = enc_i(8, 0, 2, 4, OP_LW);
        step(2);
        start();
        step(12);
        chk("jal_x0_pc", 64'(pc), 32'h20);
        chk("jal_x0_reg", 64'(dut.regs[0]), 0);
        step(16);
        chk("lw_early", 64'(dut.regs[4]), 0);
        step(1);
        chk("lw_x4", 64'(dut.regs[4]), 12);
        chk("sw_hold", 64'(st_hold), 3);
        chk("sw_mem", 64'(mem[2]), 12);

        // ---- beq taken ----
        enter_reset();
        waits   = 0;
        mem[0]  = enc_i(3, 0, 0, 1, OP_I);
        mem[1]  = enc_i(4, 0, 0, 2, OP_I);
        mem[2]  = enc_i(7, 0, 0, 0, OP_I);
        mem[3]  = enc_i(0, 0, 0, 0, OP_I);
        mem[4]  = enc_b(-8, 1, 1);
        step(2);
        start();
        step(16);
        chk("beq_at", 64'(pc), 32'h10);
        chk("x0_zero", 64'(dut.regs[0]), 0);
        step(1);
        chk("decode_pc", 64'(pc), 32'h10);
        step(2);
        chk("beq_taken", 64'(pc), 32'h08);

        // ---- beq not taken ----
        enter_reset();
        mem[0]  = enc_i(3, 0, 0, 1, OP_I);
        mem[1]  = enc_i(4, 0, 0, 2, OP_I);
        mem[2]  = enc_i(0, 0, 0, 0, OP_I);
        mem[3]  = enc_i(0, 0, 0, 0, OP_I);
        mem[4]  = enc_b(-8, 2, 1);
        step(2);
        start();
        step(19);
        chk("beq_not_taken", 64'(pc), 32'h14);

        // ---- jal with link ----
        enter_reset();
        mem[0]  = enc_j(32'h20, 0);
        mem[8]  = enc_j(16, 5);
        step(2);
        start();
        step(7);
        chk("jal_link_early", 64'(dut.regs[5]), 0);
        step(1);
        chk("jal_link", 64'(dut.regs[5]), 32'h24);
        chk("jal_target", 64'(pc), 32'h30);

        // ---- illegal opcode and illegal R-type funct3 ----
        enter_reset();
        mem[0]  = 32'h0000_007F;
        mem[1]  = enc_r(7'h00, 1, 1, 1, 1);
        mem[2]  = enc_i(9, 0, 0, 1, OP_I);
        step(2);
        start();
        for (int i = 0; i < 9; i++) begin
            step(1);
            ill_seq[i] = illegal_instr;
        end
        chk("illegal_pulses", 64'(ill_seq), 64'h012);
        chk("illegal_next", 64'(dut.regs[1]), 9);
        chk("illegal_pc", 64'(pc), 12);
        chk("illegal_ret", instret_count, PERF ? 64'd1 : 64'd0);

        // ---- reset asserted during a load wait ----
        enter_reset();
        waits   = 2;
        mem[0]  = enc_i(1, 0, 0, 1, OP_I);
        mem[1]  = enc_i(0, 0, 2, 4, OP_LW);
        step(2);
        start();
        step(11);
        chk("memrd_req", 64'(mem_req), 1);
        chk("memrd_we", 64'(mem_we), 0);
        chk("memrd_pc", 64'(pc), 4);
        chk("memrd_x1", 64'(dut.regs[1]), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_req", 64'(mem_req), 0);
        chk("abort_pc", 64'(pc), 0);
        chk("abort_regs", 64'(dut.regs[1]), 0);

        // ---- stall timeout with memory never ready ----
        enter_reset();
        stuck   = 1'b1;
        step(2);
        start();
        step(3);
        chk("to_err_early", 64'(mem_err), 0);
        chk("to_req_held", 64'(mem_req), 1);
        step(1);
        chk("to_err", 64'(mem_err), 1);
        chk("to_req_drop", 64'(mem_req), 0);
        chk("to_pc", 64'(pc), 0);
        step(1);
        chk("to_err_pulse", 64'(mem_err), 0);
        chk("to_retry", 64'(mem_req), 1);
        chk("to_retry_addr", 64'(mem_addr), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
